// File: rtl/divider_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared constants for the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int DIV_MIN  = 2;

    localparam int DUTY_50  = 0;
    localparam int DUTY_POS = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/divider_prog_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : divider_prog_if
// Brief    : Control, configuration handshake and output bundle of the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_prog_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             busy;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clk_out, tick, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clk_out, tick, busy
    );
endinterface
`default_nettype wire

// File: rtl/divider_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : divider_cfg
// Brief    : Single-entry divisor slot with valid/ready intake and reject pulse.
// Revision : 1.0 - initial release
// ============================================================================
module divider_cfg
    import divider_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  wire logic             sys_clock,
    input  wire logic             sys_rst,
    input  wire logic             cfg_valid,
    input  wire logic [DIV_W-1:0] cfg_div,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  wire logic             apply,
    output logic                  pend_valid,
    output logic [DIV_W-1:0]      pend_div
);
    logic             r_pend_valid;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_err;
    logic             w_xfer;
    logic             w_legal;

    assign w_xfer  = cfg_valid & ~r_pend_valid;
    assign w_legal = (cfg_div >= DIV_W'(DIV_MIN));

    // apply and a new transfer are mutually exclusive: apply needs a full slot
    always_ff @(posedge sys_clock or posedge sys_rst) begin
        if (sys_rst) begin
            r_pend_valid <= 1'b0;
            r_pend_div   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_legal;
            if (w_xfer && w_legal) begin
                r_pend_valid <= 1'b1;
                r_pend_div   <= cfg_div;
            end else if (apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign cfg_ready  = ~r_pend_valid;
    assign cfg_err    = r_err;
    assign pend_valid = r_pend_valid;
    assign pend_div   = r_pend_div;

endmodule
`default_nettype wire

// File: rtl/divider_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : divider_prog
// Brief    : Runtime-programmable integer clock divider, 50 % or posedge duty.
// Revision : 1.0 - initial release
// ============================================================================
module divider_prog
    import divider_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_INIT  = 5,
    parameter int DUTY_MODE = DUTY_50
) (
    input  wire logic     sys_clock,
    input  wire logic     sys_rst,
    divider_prog_if.slave bus
);
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_stop;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_half_nxt;
    logic             r_p;
    logic             w_p_nxt;
    logic             w_wrap;
    logic             w_apply;
    logic             w_pend_valid;
    logic [DIV_W-1:0] w_pend_div;
    logic             w_cfg_ready;
    logic             w_cfg_err;
    logic             w_busy;
    logic             w_tick;
    logic             w_clk;

    divider_cfg #(.DIV_W(DIV_W)) u_cfg (
        .sys_clock  (sys_clock),
        .sys_rst    (sys_rst),
        .cfg_valid  (bus.cfg_valid),
        .cfg_div    (bus.cfg_div),
        .cfg_ready  (w_cfg_ready),
        .cfg_err    (w_cfg_err),
        .apply      (w_apply),
        .pend_valid (w_pend_valid),
        .pend_div   (w_pend_div)
    );

    always_ff @(posedge sys_clock or posedge sys_rst) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A stop request only takes effect at the wrap so the last period is whole
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.en) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_wrap && (r_stop || !bus.en)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_tick = 1'b0;
        if (r_state == ST_RUN) begin
            w_busy = 1'b1;
            w_tick = (r_cnt == '0);
        end
    end

    assign w_wrap     = (r_state == ST_RUN) && (r_cnt == (r_div - DIV_W'(1)));
    assign w_apply    = w_pend_valid && ((r_state == ST_IDLE) || w_wrap);
    assign w_div_nxt  = w_apply ? w_pend_div : r_div;
    assign w_cnt_nxt  = ((r_state == ST_RUN) && (w_state_nxt == ST_RUN) && !w_wrap)
                        ? (r_cnt + DIV_W'(1)) : '0;
    // ceil(N/2); phase is evaluated against the divisor of the coming cycle
    assign w_half_nxt = DIV_W'(w_div_nxt[DIV_W-1:1]) + DIV_W'(w_div_nxt[0]);
    assign w_p_nxt    = (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_half_nxt);

    always_ff @(posedge sys_clock or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt  <= '0;
            r_div  <= DIV_W'(DIV_INIT);
            r_p    <= 1'b0;
            r_stop <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_div  <= w_div_nxt;
            r_p    <= w_p_nxt;
            r_stop <= (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && (r_stop || !bus.en);
        end
    end

    if (DUTY_MODE == DUTY_POS) begin : g_dutypos
        assign w_clk = r_p;
    end else begin : g_duty50
        logic r_n;

        // Half-cycle delayed copy trims odd-N high time to exactly N/2
        always_ff @(negedge sys_clock or posedge sys_rst) begin
            if (sys_rst) r_n <= 1'b0;
            else         r_n <= r_p;
        end

        assign w_clk = r_div[0] ? (r_p & r_n) : r_p;
    end

    assign bus.clk_out   = w_clk;
    assign bus.tick      = w_tick;
    assign bus.busy      = w_busy;
    assign bus.cfg_ready = w_cfg_ready;
    assign bus.cfg_err   = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_divider_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_divider_prog
// Brief    : Self-checking bench: vector table, directed corners, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_prog;

    logic       sys_clock = 1'b0;
    logic       sys_rst   = 1'b1;
    logic       en        = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div   = 8'd0;

    int errors = 0;
    int checks = 0;

    always #10 sys_clock = ~sys_clock;

    divider_prog_if #(.DIV_W(8)) if0 ();
    divider_prog_if #(.DIV_W(8)) if1 ();

    assign if0.en = en;  assign if0.cfg_valid = cfg_valid;  assign if0.cfg_div = cfg_div;
    assign if1.en = en;  assign if1.cfg_valid = cfg_valid;  assign if1.cfg_div = cfg_div;

    divider_prog #(.DIV_W(8), .DIV_INIT(5), .DUTY_MODE(divider_pkg::DUTY_50)) dut0 (
        .sys_clock (sys_clock), .sys_rst (sys_rst), .bus (if0));
    divider_prog #(.DIV_W(8), .DIV_INIT(5), .DUTY_MODE(divider_pkg::DUTY_POS)) dut1 (
        .sys_clock (sys_clock), .sys_rst (sys_rst), .bus (if1));

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current period and divisor bookkeeping
    bit m_run = 0, m_pend_v = 0, m_stopreq = 0, m_err = 0;
    int m_pos = 0, m_n = 5, m_pend = 0;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = 5; m_pend = 0;
        m_pend_v = 0; m_stopreq = 0; m_err = 0;
    endtask

    task automatic model_step(input logic e, input logic v, input int d);
        bit xfer, wrap, apply;
        xfer  = v && !m_pend_v;
        wrap  = m_run && (m_pos == m_n - 1);
        apply = m_pend_v && (!m_run || wrap);
        if (m_run) begin
            if (!e) m_stopreq = 1;
            if (wrap) begin
                m_pos = 0;
                if (m_stopreq) begin m_run = 0; m_stopreq = 0; end
            end else begin
                m_pos++;
            end
        end else if (e) begin
            m_run = 1; m_pos = 0;
        end
        if (apply) begin m_n = m_pend; m_pend_v = 0; end
        m_err = xfer && (d < 2);
        if (xfer && d >= 2) begin m_pend_v = 1; m_pend = d; end
    endtask

    // 50 % mode: high for exactly N half-cycles, starting half a cycle late for odd N
    function automatic logic exp_clk0(input int h);
        if (!m_run) return 1'b0;
        if (m_n % 2 == 0) return h < m_n;
        return (h >= 1) && (h <= m_n);
    endfunction

    function automatic logic exp_clk1();
        return m_run && (m_pos < (m_n + 1) / 2);
    endfunction

    always @(posedge sys_rst) model_reset();

    always begin
        @(posedge sys_clock);
        if (sys_rst) model_reset();
        else         model_step(en, cfg_valid, int'(cfg_div));
        #2;
        chk("tick0",  if0.tick,      m_run && m_pos == 0);
        chk("busy0",  if0.busy,      m_run);
        chk("ready0", if0.cfg_ready, !m_pend_v);
        chk("err0",   if0.cfg_err,   m_err);
        chk("clk0_a", if0.clk_out,   exp_clk0(2 * m_pos));
        chk("tick1",  if1.tick,      m_run && m_pos == 0);
        chk("ready1", if1.cfg_ready, !m_pend_v);
        chk("clk1_a", if1.clk_out,   exp_clk1());
        @(negedge sys_clock);
        #2;
        chk("clk0_b", if0.clk_out,   exp_clk0(2 * m_pos + 1));
        chk("clk1_b", if1.clk_out,   exp_clk1());
    end

    task automatic cyc();
        @(posedge sys_clock);
        #5;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(posedge sys_clock);
            #2;
            n++;
        end while (!if0.tick && n < budget);
        chk("tick_seen", if0.tick, 1'b1);
    endtask

    // Entered 2 ns after a tick posedge; returns 2 ns after the next tick posedge
    task automatic measure(output int per, output int hi0, output int hi1);
        per = 0; hi0 = 0; hi1 = 0;
        do begin
            per++;
            if (if0.clk_out) hi0++;
            if (if1.clk_out) hi1++;
            @(negedge sys_clock);
            #2;
            if (if0.clk_out) hi0++;
            @(posedge sys_clock);
            #2;
        end while (!if0.tick && per < 600);
    endtask

    task automatic check_period(input string name, input int e_per, input int e_hi0, input int e_hi1);
        int per, hi0, hi1;
        measure(per, hi0, hi1);
        chk_int({name, "_period"}, per, e_per);
        chk_int({name, "_hi_halves50"}, hi0, e_hi0);
        chk_int({name, "_hi_cycles_pos"}, hi1, e_hi1);
    endtask

    task automatic offer(input logic [7:0] d, input bit ok);
        int k = 0;
        while (!if0.cfg_ready && k < 600) begin cyc(); k++; end
        chk("offer_ready_before", if0.cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_div   = d;
        @(posedge sys_clock);
        #2;
        chk("offer_err", if0.cfg_err, !ok);
        chk("offer_ready_after", if0.cfg_ready, !ok);
        #3;
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] div;
        bit         ok;
        int         per;
        int         hi0;
        int         hi1;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   n;

        vecs[0] = '{8'd1,   1'b0, 4,   4,   2};
        vecs[1] = '{8'd7,   1'b1, 7,   7,   4};
        vecs[2] = '{8'd0,   1'b0, 7,   7,   4};
        vecs[3] = '{8'd2,   1'b1, 2,   2,   1};
        vecs[4] = '{8'd3,   1'b1, 3,   3,   2};
        vecs[5] = '{8'd255, 1'b1, 255, 255, 128};
        vecs[6] = '{8'd8,   1'b1, 8,   8,   4};
        vecs[7] = '{8'd4,   1'b1, 4,   4,   2};
        vecs[8] = '{8'd5,   1'b1, 5,   5,   3};

        repeat (3) @(posedge sys_clock);
        #5;
        chk("rst_clk0",  if0.clk_out,   1'b0);
        chk("rst_clk1",  if1.clk_out,   1'b0);
        chk("rst_tick",  if0.tick,      1'b0);
        chk("rst_busy",  if0.busy,      1'b0);
        chk("rst_ready", if0.cfg_ready, 1'b1);
        chk("rst_err",   if0.cfg_err,   1'b0);
        sys_rst = 1'b0;
        cyc(); cyc();

        en = 1'b1;
        @(posedge sys_clock);
        #2;
        chk("first_tick", if0.tick,    1'b1);
        chk("first_busy", if0.busy,    1'b1);
        chk("first_clk1", if1.clk_out, 1'b1);
        check_period("init5", 5, 5, 3);

        // New divisor offered in the middle of an N=5 period
        #3;
        cyc();
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        @(posedge sys_clock);
        #2;
        chk("mid_ready_low", if0.cfg_ready, 1'b0);
        #3;
        cfg_valid = 1'b0;
        wait_tick(20, n);
        chk_int("mid_old_rest", n, 3);
        check_period("mid4", 4, 4, 2);

        for (int i = 0; i < 9; i++) begin
            #3;
            offer(vecs[i].div, vecs[i].ok);
            wait_tick(600, n);
            check_period($sformatf("vec%0d", i), vecs[i].per, vecs[i].hi0, vecs[i].hi1);
        end

        // Stop request at cnt=2 of an N=6 period
        #3;
        offer(8'd6, 1'b1);
        wait_tick(20, n);
        check_period("n6", 6, 6, 3);
        #3;
        cyc();
        cyc();
        en = 1'b0;
        n  = 0;
        do begin
            @(posedge sys_clock);
            #2;
            n++;
        end while (if0.busy && n < 20);
        chk_int("stop_cycles", n, 4);
        #3;
        cyc();
        cyc();
        chk("idle_clk0", if0.clk_out, 1'b0);
        chk("idle_clk1", if1.clk_out, 1'b0);
        en = 1'b1;
        @(posedge sys_clock);
        #2;
        chk("restart_tick", if0.tick, 1'b1);
        chk("restart_busy", if0.busy, 1'b1);
        check_period("restart6", 6, 6, 3);

        // Asynchronous reset while clk_out is high
        #5;
        chk("pre_rst_clk0", if0.clk_out, 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("arst_clk0", if0.clk_out, 1'b0);
        chk("arst_clk1", if1.clk_out, 1'b0);
        chk("arst_tick", if0.tick,    1'b0);
        chk("arst_busy", if0.busy,    1'b0);
        @(posedge sys_clock);
        #5;
        chk("arst_ready", if0.cfg_ready, 1'b1);
        sys_rst = 1'b0;
        @(posedge sys_clock);
        #2;
        chk("post_rst_tick", if0.tick, 1'b1);
        check_period("post_rst5", 5, 5, 3);

        #3;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_div   = 8'($urandom_range(0, 12));
            end else begin
                cfg_valid = 1'b0;
            end
            cyc();
        end
        cfg_valid = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/divider_prog.md
# divider_prog

Runtime-programmable integer clock divider, the parametrised successor of the fixed odd divider. It divides `sys_clock` by any N from 2 to 2^DIV_W−1, odd or even, at exact 50 % duty or posedge-only duty. The divisor is loaded through a valid/ready handshake and applied glitch-free only at a period boundary. It sits beside the clock source and feeds slow clock/strobe consumers, with a single-cycle `tick` strobe for logic that stays in the `sys_clock` domain.

## Interface
- `DIV_W`, 8: divisor width; legal N = 2 … 2^DIV_W−1.
- `DIV_INIT`, 5: divisor active out of reset; must be ≥ 2.
- `DUTY_MODE`, 0: 0 = exact 50 % using a negedge flop for odd N; 1 = posedge-only flops, high for ceil(N/2) cycles.
- `sys_clock`  in  1  single clock; only this clock, both edges in DUTY_MODE 0.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  DIV_W  offered divisor N.
- `cfg_ready`  out  1  divisor slot free.
- `cfg_err`  out  1  one-cycle pulse when an offered divisor is rejected (N<2).
- `clk_out`  out  1  divided clock.
- `tick`  out  1  one-cycle strobe in the cycle that `clk_out` rises.
- `busy`  out  1  high while periods are being generated.

## Operation
- Reset values: `clk_out`=0, `tick`=0, `busy`=0, `cfg_ready`=1, `cfg_err`=0. Period counter `cnt`=0, active divisor = DIV_INIT, pending slot empty. Reset is asynchronous and aborts any period immediately.
- `cnt` runs 0 … N−1 then wraps to 0 while running.
- Posedge phase `p` = (cnt < H), where H = N/2 for even N and (N+1)/2 for odd N.
- DUTY_MODE 0:
  - Even N: `clk_out` = `p`.
  - Odd N: `clk_out` = `p` AND `n`, where `n` is `p` re-sampled on the falling edge. High time is exactly N/2 `sys_clock` periods.
- DUTY_MODE 1: `clk_out` = `p`.
- State machine:
  - IDLE: `busy`=0, `clk_out`=0. `en`=1 moves to RUN, with `cnt`=0 on the next posedge.
  - RUN: generates periods. When `en` is sampled 0, the current period completes, then the block enters IDLE at the wrap instead of restarting.
- Handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready` at a posedge.
  - N ≥ 2: the value goes to the pending slot and `cfg_ready` drops the next cycle.
  - N < 2: not stored, `cfg_ready` stays 1, and `cfg_err` pulses the next cycle.
  - A pending divisor becomes active on the wrap posedge (cnt N−1→0) in RUN, or on the next posedge in IDLE. `cfg_ready` returns to 1 in the following cycle.
  - A transfer and a wrap in the same cycle: the new value waits for the next wrap. No period ever mixes two divisors.
- `tick` = 1 exactly in the cycles where cnt==0 in RUN.

## Timing
- First `clk_out` rise: at the first posedge after `en` is sampled high in IDLE. `tick` is high in that same cycle.
- Period: exactly N `sys_clock` cycles between consecutive `tick`s.
- Divisor-change latency: the new N is active from the first wrap after acceptance. Worst case is N_old cycles.
- Reset deassertion is honoured on the first posedge after release. Behaviour in that cycle is otherwise identical to IDLE.

## Structure
- Shared package `divider_pkg`:
  - `DIV_MIN` = 2.
  - DUTY_MODE encodings `DUTY_50` = 0, `DUTY_POS` = 1.
  - IDLE/RUN state encoding.
- Sub-module `divider_cfg`: pending-slot register plus valid/ready/err logic. Outputs `pend_valid`/`pend_div`; input `apply` strobe from the counter.
- Top: state machine, counter, phase flops, negedge flop, output gating.

## Test plan
- Reset, DIV_INIT=5, DUTY_MODE 0, `en`=1, 20 ns clock → `clk_out` period 100 ns, high exactly 50 ns, `tick` every 5 cycles, first `tick` on the first posedge after `en` is sampled.
- Load N=4 mid-period of N=5, handshake accepted → current period stays 5 cycles, then 80 ns periods with 40 ns high. `cfg_ready` is low from acceptance until the cycle after the wrap.
- Offer N=1 and N=0 → `cfg_err` pulses once each, `cfg_ready` stays 1, period unchanged.
- DUTY_MODE 1, N=7 → high 4 cycles, low 3 cycles, no negedge dependence.
- Drop `en` at cnt=2, N=6 → period completes (6 cycles), `busy` falls, `clk_out` held 0. Re-raise `en` → restart at cnt=0 with a `tick`.
- Assert `sys_rst` asynchronously between edges while `clk_out`=1 → `clk_out`, `tick` and `busy` are 0 immediately. On release the active divisor is DIV_INIT and `cfg_ready`=1.
